// File: rtl/tampon_tx.sv
// tampon_tx: FIFO of Enigma letter indices feeding the UART transmitter as ASCII bytes.
// Define TAMPON_TX_GRUPARE_EN to insert a space between groups of GROUP_LEN letters.
module tampon_tx #(
    parameter int ADDR_W    = 4,
    parameter int GROUP_LEN = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [4:0]        char_in,
    input  logic              tx_active,
    output logic              tx_start,
    output logic [7:0]        tx_din,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [1:0]        dbg_state
);

    // Handshake: valid_in is a one-cycle strobe accepted whenever full=0 (no
    // backpressure, a strobe while full is dropped and flagged in overflow);
    // tx_start is a one-cycle pulse issued only while tx_active=0, and tx_din
    // then holds the byte until the next pop.

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CW    = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    logic [4:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    state_t            state;
    logic [1:0]        hi_wait;
    logic              push;
    logic              go;
    logic              pop;
    logic              send_space;

    if (ADDR_W < 1 || GROUP_LEN < 1) begin : g_bad_param
        $error("tampon_tx: ADDR_W and GROUP_LEN must be at least 1");
    end

    function automatic logic [7:0] to_ascii(input logic [4:0] idx);
        if (idx < 5'd26)
            return 8'h41 + {3'b000, idx};
        else
            return 8'h3F;
    endfunction

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign push      = valid_in && !full;
    // A pending space only goes out ahead of a real letter, so no trailing space.
    assign go        = (state == IDLE) && !tx_active && !empty;
    assign pop       = go && !send_space;
    assign dbg_state = state;

`ifdef TAMPON_TX_GRUPARE_EN
    localparam int GW = $clog2(GROUP_LEN + 1);

    logic [GW-1:0] grp_cnt;
    logic          space_pend;

    assign send_space = space_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            grp_cnt    <= '0;
            space_pend <= 1'b0;
        end else if (pop) begin
            if (grp_cnt == GW'(GROUP_LEN - 1)) begin
                grp_cnt    <= '0;
                space_pend <= 1'b1;
            end else begin
                grp_cnt <= grp_cnt + GW'(1);
            end
        end else if (go && space_pend) begin
            space_pend <= 1'b0;
        end
    end
`else
    assign send_space = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= char_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + ADDR_W'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
            if (valid_in && full)
                overflow <= 1'b1;
        end
    end

    // WAIT_HI gives a slow transmitter three cycles to raise tx_active
    // before the byte is assumed to have gone out.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            tx_din   <= 8'h00;
            hi_wait  <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    tx_start <= 1'b0;
                    if (go) begin
                        state    <= START;
                        tx_start <= 1'b1;
                        tx_din   <= send_space ? 8'h20 : to_ascii(mem[rd_ptr]);
                    end
                end
                START: begin
                    tx_start <= 1'b0;
                    hi_wait  <= 2'd0;
                    state    <= WAIT_HI;
                end
                WAIT_HI: begin
                    tx_start <= 1'b0;
                    if (tx_active) begin
                        state <= WAIT_LO;
                    end else if (hi_wait == 2'd2) begin
                        state <= IDLE;
                    end else begin
                        hi_wait <= hi_wait + 2'd1;
                    end
                end
                WAIT_LO: begin
                    tx_start <= 1'b0;
                    if (!tx_active)
                        state <= IDLE;
                end
                default: begin
                    tx_start <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tampon_tx.sv
// Bench for tampon_tx: a UART model on the negative edge, a byte scoreboard,
// a table-driven burst and hand-written multi-cycle sequences.
module tb_tampon_tx;

    localparam int ADDR_W    = 4;
    localparam int GROUP_LEN = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            valid_in;
    logic [4:0]      char_in;
    logic            tx_active;
    logic            tx_start;
    logic [7:0]      tx_din;
    logic            empty;
    logic            full;
    logic [ADDR_W:0] count;
    logic            overflow;
    logic [1:0]      dbg_state;

    tampon_tx #(.ADDR_W(ADDR_W), .GROUP_LEN(GROUP_LEN)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .char_in(char_in),
        .tx_active(tx_active), .tx_start(tx_start), .tx_din(tx_din),
        .empty(empty), .full(full), .count(count), .overflow(overflow),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // scoreboard
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int tests = 0;
    int fails = 0;
    int starts = 0;
    int grp_model = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_ascii(input int idx);
        if (idx < 26)
            return 8'(65 + idx);
        return 8'h3F;
    endfunction

    // UART model: busy for uart_len cycles after each start unless deaf
    logic       uart_hold = 1'b0;
    logic       uart_busy = 1'b0;
    logic       uart_deaf = 1'b0;
    int         uart_len = 4;
    int         busy_cnt = 0;
    logic [7:0] cur_byte = 8'h00;
    logic       prev_start = 1'b0;
    logic       prev_active = 1'b0;

    assign tx_active = uart_hold | uart_busy;

    always @(negedge clk) begin
        logic act_now;
        act_now = tx_active;
        if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                check("tx_din_stable", tx_din, cur_byte);
                uart_busy = 1'b0;
            end
        end
        if (tx_start) begin
            starts++;
            got_q.push_back(tx_din);
            check("start_one_cycle", prev_start, 0);
            check("start_after_idle", prev_active, 0);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_start: got %0h expected none", tx_din);
            end else begin
                check("byte", tx_din, exp_q.pop_front());
            end
            cur_byte = tx_din;
            if (!uart_deaf) begin
                uart_busy = 1'b1;
                busy_cnt  = uart_len;
            end
        end
        prev_start  = tx_start;
        prev_active = act_now;
    end

    // driver tasks (called at a negative edge, return at a negative edge)
    task automatic model_push(input logic [4:0] c);
`ifdef TAMPON_TX_GRUPARE_EN
        if (grp_model == GROUP_LEN) begin
            exp_q.push_back(8'h20);
            grp_model = 0;
        end
        grp_model++;
`endif
        exp_q.push_back(exp_ascii(int'(c)));
    endtask

    task automatic push(input logic [4:0] c, input logic accept);
        valid_in = 1'b1;
        char_in  = c;
        if (accept)
            model_push(c);
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        valid_in  = 1'b0;
        cur_byte  = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        grp_model = 0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (!(exp_q.size() == 0 && empty && !tx_active && dbg_state == 2'd0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    typedef struct {
        logic [4:0] ch;
        logic       hold;
        logic       acc;
        logic [4:0] exp_count;
        logic       exp_full;
        logic       exp_ovf;
    } vec_t;

    vec_t vec[17];

    initial begin
        int s0;
        int exp_cnt;
        string s;
        string exp_s;
        logic [4:0] hello[12];

        for (int i = 0; i < 16; i++)
            vec[i] = '{ch: 5'(i), hold: 1'b1, acc: 1'b1, exp_count: 5'(i + 1),
                       exp_full: (i == 15), exp_ovf: 1'b0};
        // 17th strobe lands with a pop in the same cycle: still dropped
        vec[16] = '{ch: 5'd20, hold: 1'b0, acc: 1'b0, exp_count: 5'd15,
                    exp_full: 1'b0, exp_ovf: 1'b1};

        hello = '{5'd7, 5'd4, 5'd11, 5'd11, 5'd14, 5'd22, 5'd14, 5'd17, 5'd11, 5'd3, 5'd23, 5'd24};

        rst = 1'b1;
        valid_in = 1'b0;
        char_in = 5'd0;
        repeat (3) @(negedge clk);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_din", tx_din, 8'h00);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_overflow", overflow, 0);
        rst = 1'b0;
        @(negedge clk);

        // single letter: start two cycles after the strobe
        push(5'd0, 1'b1);
        check("single_count1", count, 1);
        check("single_empty0", empty, 0);
        check("single_nostart", tx_start, 0);
        @(negedge clk);
        check("single_start", tx_start, 1);
        check("single_din", tx_din, 8'h41);
        check("single_count0", count, 0);
        @(negedge clk);
        check("single_pulse_end", tx_start, 0);
        wait_drain("drain_single", 200);

        // simultaneous push and pop keeps count
        uart_hold = 1'b1;
        push(5'd1, 1'b1);
        push(5'd2, 1'b1);
        check("pp_count_pre", count, 2);
        uart_hold = 1'b0;
        push(5'd3, 1'b1);
        check("pp_count_same", count, 2);
        wait_drain("drain_pp", 500);

        // burst into a held UART, then overflow
        for (int i = 0; i < 17; i++) begin
            uart_hold = vec[i].hold;
            push(vec[i].ch, vec[i].acc);
            check($sformatf("burst_count_%0d", i), count, vec[i].exp_count);
            check($sformatf("burst_full_%0d", i), full, vec[i].exp_full);
            check($sformatf("burst_ovf_%0d", i), overflow, vec[i].exp_ovf);
        end
        wait_drain("drain_burst", 2000);
        check("ovf_sticky", overflow, 1);
        check("burst_empty", empty, 1);

        // busy handshake with a slow UART
        uart_len = 100;
        s0 = starts;
        push(5'd10, 1'b1);
        push(5'd11, 1'b1);
        push(5'd12, 1'b1);
        wait_drain("drain_busy", 1000);
        check("busy_starts", starts - s0, 3);

        // reset mid-operation
        exp_cnt = 5;
`ifdef TAMPON_TX_GRUPARE_EN
        if (grp_model == GROUP_LEN)
            exp_cnt = 6;
`endif
        for (int i = 0; i < 6; i++)
            push(5'(i + 4), 1'b1);
        check("mid_count_pre", count, 32'(exp_cnt));
        check("mid_active", tx_active, 1);
        do_reset();
        check("mid_count", count, 0);
        check("mid_empty", empty, 1);
        check("mid_overflow", overflow, 0);
        s0 = starts;
        repeat (120) @(negedge clk);
        check("mid_no_start", starts - s0, 0);
        uart_len = 4;
        push(5'd2, 1'b1);
        wait_drain("drain_mid", 300);
        check("mid_restart", starts - s0, 1);

        // grouping stream
        do_reset();
        uart_len = 3;
        got_q.delete();
        for (int i = 0; i < 12; i++)
            push(hello[i], 1'b1);
        wait_drain("drain_hello", 1000);
`ifdef TAMPON_TX_GRUPARE_EN
        exp_s = "HELLO WORLD XY";
`else
        exp_s = "HELLOWORLDXY";
`endif
        s = "";
        foreach (got_q[i])
            s = $sformatf("%s%c", s, got_q[i]);
        tests++;
        if (s != exp_s) begin
            fails++;
            $display("FAIL hello_stream: got \"%s\" expected \"%s\"", s, exp_s);
        end

        // out-of-range indices, then a UART that never answers
        push(5'd31, 1'b1);
        push(5'd26, 1'b1);
        push(5'd25, 1'b1);
        wait_drain("drain_range", 500);
        check("range_last_din", tx_din, 8'h5A);
        uart_deaf = 1'b1;
        push(5'd8, 1'b1);
        push(5'd9, 1'b1);
        wait_drain("drain_deaf", 300);
        uart_deaf = 1'b0;

        // 40 letters through depth 16: pointer wrap
        for (int i = 0; i < 40; i++) begin
            int w = 0;
            while (full && w < 300) begin
                @(negedge clk);
                w++;
            end
            if (full)
                check("wrap_not_full", full, 0);
            push(5'($urandom_range(0, 25)), 1'b1);
        end
        wait_drain("drain_wrap", 3000);
        check("wrap_overflow", overflow, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
